// File: rtl/conv_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_encoder_pkg
// Purpose: Shared constants and types for the rate-1/2, K=7 convolutional
//          encoder. The encoder core is also reused by decoder benches as
//          a reference model, so its code constants are kept here.
// Contents:
//    K_CONV, WD_FSM, WD_CODE, WD_LEN   - widths
//    G0_CONV, G1_CONV                  - generator polynomials (171/133 oct)
//    TAIL_LAST                         - index of the final tail symbol
//    enc_state_t                       - frame FSM encoding
// Revision: 1.0 - initial release
// ============================================================================
package conv_encoder_pkg;

   localparam int K_CONV  = 7;
   localparam int WD_FSM  = K_CONV - 1;
   localparam int WD_CODE = 2;
   localparam int WD_LEN  = 16;

   // Bit 6 taps the incoming bit, bit 5 the most recent prior bit.
   localparam logic [K_CONV-1:0] G0_CONV = 7'b1111001;
   localparam logic [K_CONV-1:0] G1_CONV = 7'b1011011;

   // Tail symbols are numbered 0..5; the last one flushes the register.
   localparam logic [2:0] TAIL_LAST = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_TAIL = 2'd2
   } enc_state_t;

endpackage : conv_encoder_pkg
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ============================================================================
// Module : conv_enc_core
// Purpose: Purely combinational K=7 encoder step: (bit, state) -> (code,
//          next state). Usable standalone as a reference model.
// Ports  :
//    bit_i    in  1        information (or tail) bit
//    state_i  in  WD_FSM   shift register, [5] = most recent prior bit
//    code_o   out WD_CODE  {c1,c0}, c1 from G0, c0 from G1
//    state_o  out WD_FSM   shift register after this bit
// Revision: 1.0 - initial release
// ============================================================================
module conv_enc_core
   import conv_encoder_pkg::*;
(
   input  logic                bit_i,
   input  logic [WD_FSM-1:0]   state_i,
   output logic [WD_CODE-1:0]  code_o,
   output logic [WD_FSM-1:0]   state_o
);

   logic [K_CONV-1:0] taps;

   assign taps    = {bit_i, state_i};
   assign code_o  = {^(G0_CONV & taps), ^(G1_CONV & taps)};
   assign state_o = {bit_i, state_i[WD_FSM-1:1]};

endmodule : conv_enc_core
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module : conv_encoder
// Purpose: Frame-based rate-1/2, K=7 convolutional encoder. Accepts FrameLen
//          information bits, then appends six zero tail bits so each frame
//          terminates in state 0. Registered valid/ready symbol output.
// Ports  :
//    Clock2     in  1        system clock, rising edge
//    Reset      in  1        asynchronous active-low reset
//    Start      in  1        frame start pulse, honoured in IDLE only
//    FrameLen   in  WD_LEN   information bits in frame, sampled on Start
//    InValid    in  1        InBit valid
//    InBit      in  1        information bit
//    InReady    out 1        InBit accepted this cycle
//    Code       out WD_CODE  encoded symbol {c1,c0}
//    CodeValid  out 1        Code holds a valid symbol
//    CodeReady  in  1        downstream accepts Code
//    CodeLast   out 1        final tail symbol of the frame
//    Busy       out 1        FSM not in IDLE
// Revision: 1.0 - initial release
// ============================================================================
module conv_encoder
   import conv_encoder_pkg::*;
(
   input  logic                Clock2,
   input  logic                Reset,
   input  logic                Start,
   input  logic [WD_LEN-1:0]   FrameLen,
   input  logic                InValid,
   input  logic                InBit,
   output logic                InReady,
   output logic [WD_CODE-1:0]  Code,
   output logic                CodeValid,
   input  logic                CodeReady,
   output logic                CodeLast,
   output logic                Busy
);

   enc_state_t           state_q, state_d;
   logic [WD_LEN-1:0]    len_q, len_d;
   logic [WD_LEN-1:0]    cnt_q, cnt_d;
   logic [2:0]           tail_q, tail_d;
   logic [WD_FSM-1:0]    shreg_q;
   logic [WD_CODE-1:0]   code_q;
   logic                 valid_q;
   logic                 last_q;

   logic                 slot_free;
   logic                 load;
   logic                 enc_bit;
   logic                 last_d;
   logic [WD_CODE-1:0]   enc_code;
   logic [WD_FSM-1:0]    enc_state;

   conv_enc_core u_core (
      .bit_i   (enc_bit),
      .state_i (shreg_q),
      .code_o  (enc_code),
      .state_o (enc_state)
   );

   // The output slot can take a new symbol if empty or being drained now.
   assign slot_free = !valid_q || CodeReady;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      tail_d  = tail_q;
      load    = 1'b0;
      enc_bit = 1'b0;
      last_d  = 1'b0;
      InReady = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               len_d   = FrameLen;
               cnt_d   = '0;
               tail_d  = '0;
               state_d = (FrameLen == '0) ? ST_TAIL : ST_DATA;
            end
         end
         ST_DATA: begin
            InReady = slot_free;
            if (InValid && slot_free) begin
               load    = 1'b1;
               enc_bit = InBit;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == len_q - 1'b1) begin
                  state_d = ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            // Zero bits are pushed through; after six the register is 0.
            if (slot_free) begin
               load   = 1'b1;
               tail_d = tail_q + 1'b1;
               if (tail_q == TAIL_LAST) begin
                  last_d  = 1'b1;
                  tail_d  = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock2 or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         tail_q  <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         tail_q  <= tail_d;
         if (load) begin
            shreg_q <= enc_state;
         end
      end
   end

   // Output register: holds steady under backpressure, empties when drained.
   always_ff @(posedge Clock2 or negedge Reset) begin
      if (!Reset) begin
         code_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load) begin
         code_q  <= enc_code;
         valid_q <= 1'b1;
         last_q  <= last_d;
      end else if (CodeReady) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   assign Code      = code_q;
   assign CodeValid = valid_q;
   assign CodeLast  = last_q;
   assign Busy      = (state_q != ST_IDLE);

endmodule : conv_encoder
`default_nettype wire
